// File: rtl/btn_pkg.sv
// Shared constants and the event-word builder for the button event queue.
package btn_pkg;

    localparam int NUM_BTN    = 5;
    localparam int EV_W       = 26;
    localparam int EV_TAG_BIT = 3;
    localparam int IDX_W      = 3;

    typedef logic [NUM_BTN-1:0] btn_mask_t;
    typedef logic [IDX_W-1:0]   btn_idx_t;

    // Key code: index in the low bits, tag bit marks a real event, rest zero.
    function automatic logic [EV_W-1:0] make_event(input btn_idx_t idx);
        logic [EV_W-1:0] w;
        w               = '0;
        w[IDX_W-1:0]    = idx;
        w[EV_TAG_BIT]   = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/btn_queue_debounce.sv
// Per-button debouncer: a level flips only after DEBOUNCE_CYCLES disagreeing
// samples; a press pulse follows one cycle after each 0->1 flip.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic press
);

    localparam int         CNT_W    = 8;
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             stable_reg, stable_next;
    logic             stable_d_reg;
    logic             press_reg;

    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        if (din == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            stable_next = ~stable_reg;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // stable_d lags stable by one edge so the press pulse lands a cycle after the flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            press_reg    <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            stable_reg   <= stable_next;
            stable_d_reg <= stable_reg;
            press_reg    <= stable_reg & ~stable_d_reg;
        end
    end

    assign stable = stable_reg;
    assign press  = press_reg;

endmodule

// File: rtl/btn_queue.sv
// Button event source: synchronize, debounce, latch presses in a pending mask,
// and feed them lowest-index-first into a small FIFO popped by the CPU.
module btn_queue
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               rd_en,
    output logic               ev_valid,
    output logic [EV_W-1:0]    ev_data,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    btn_mask_t sync1_reg, sync2_reg;
    btn_mask_t stable_vec_unused;
    btn_mask_t press_vec;
    btn_mask_t pend_reg, pend_next;
    btn_mask_t clr_mask;

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    btn_idx_t         mem [FIFO_DEPTH];

    btn_idx_t grant_idx;
    logic     full, empty, push, pop;
    logic     ovf_reg, ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
            debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst_n  (rst_n),
                .din    (sync2_reg[gi]),
                .stable (stable_vec_unused[gi]),
                .press  (press_vec[gi])
            );
        end
    endgenerate

    // Lowest set pending bit wins; scanning downward leaves the lowest index last.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign pop   = rd_en & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push  = (|pend_reg) & (~full | pop);

    always_comb begin
        clr_mask = '0;
        if (push) begin
            clr_mask[grant_idx] = 1'b1;
        end
        pend_next = (pend_reg & ~clr_mask) | press_vec;
        ovf_set   = |(press_vec & pend_reg & ~clr_mask);
    end

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // Slot contents need no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= grant_idx;
        end
    end

    assign ev_valid = ~empty;
    assign ev_data  = empty ? '0 : make_event(mem[rd_ptr_reg]);
    assign ovf      = ovf_reg;

endmodule
